pipeexe_emreg: RTL and testbench



---
 rtl/pipeexe_emreg_if.sv | 38 +++
 rtl/pipeexe_emreg.sv | 137 +++++++++++++
 tb/tb_pipeexe_emreg.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeexe_emreg_if.sv
// rtl/pipeexe_emreg_if.sv - D/E bundle in, E/M register out, stall and forwarding taps
interface pipeexe_emreg_if;
  // D/E bundle presented to the execute stage
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [31:0] epc4;
  logic [4:0]  ern0;
  // combinational taps back to decode
  logic [4:0]  ern;
  logic        estall;
  // E/M pipeline register
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mrn;

  modport master (
    output ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal,
           ea, eb, eimm, epc4, ern0,
    input  ern, estall, mwreg, mm2reg, mwmem, malu, mb, mrn
  );

  modport slave (
    input  ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal,
           ea, eb, eimm, epc4, ern0,
    output ern, estall, mwreg, mm2reg, mwmem, malu, mb, mrn
  );
endinterface

// File: rtl/pipeexe_emreg.sv
// rtl/pipeexe_emreg.sv - execute stage ALU and E/M register; iterative multiplier under PIPE_MUL_EN
module pipeexe_emreg #(
  parameter logic [3:0] MUL_CODE = 4'b1011,
  parameter logic [4:0] JAL_REG  = 5'd31
) (
  input logic            clock,
  input logic            resetn,
  pipeexe_emreg_if.slave bus
);

  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] alu_out;
  logic [31:0] result;
  logic [31:0] em_alu;
  logic [4:0]  ern_int;
  logic        is_mul;
  logic        stall_int;

  logic        mwreg_q;
  logic        mm2reg_q;
  logic        mwmem_q;
  logic [31:0] malu_q;
  logic [31:0] mb_q;
  logic [4:0]  mrn_q;

  assign opa     = bus.eshift ? {27'b0, bus.eimm[10:6]} : bus.ea;
  assign opb     = bus.ealuimm ? bus.eimm : bus.eb;
  assign ern_int = bus.ejal ? JAL_REG : bus.ern0;
  // jal takes priority, so a jal never starts a multiply
  assign is_mul  = (bus.ealuc == MUL_CODE) && !bus.ejal;

  // single-cycle ALU; the multiply code yields 0 here
  always_comb begin
    alu_out = '0;
    case (bus.ealuc[2:0])
      3'b000:  alu_out = opa + opb;
      3'b100:  alu_out = opa - opb;
      3'b001:  alu_out = opa & opb;
      3'b101:  alu_out = opa | opb;
      3'b010:  alu_out = opa ^ opb;
      3'b110:  alu_out = {opb[15:0], 16'b0};
      3'b011:  alu_out = bus.ealuc[3] ? 32'b0 : (opb << opa[4:0]);
      3'b111:  alu_out = bus.ealuc[3] ? 32'($signed(opb) >>> opa[4:0])
                                      : (opb >> opa[4:0]);
      default: alu_out = '0;
    endcase
  end

  assign result = bus.ejal ? (bus.epc4 + 32'd4) : (is_mul ? 32'b0 : alu_out);

`ifdef PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;

  // shift-add multiplier: load in IDLE, 32 BUSY steps, hand result over in DONE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mcand  <= opa;
            mplier <= opb;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= {mcand[30:0], 1'b0};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_int  = (state == BUSY) || ((state == IDLE) && is_mul);
  // reset must drop the stall at once even though IDLE sees a MUL on the inputs
  assign bus.estall = resetn & stall_int;
  assign em_alu     = (state == DONE) ? acc : result;
`else
  assign stall_int  = 1'b0;
  assign bus.estall = 1'b0;
  assign em_alu     = result;
`endif

  // E/M pipeline register; a stall cycle inserts a bubble
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= '0;
      mb_q     <= '0;
      mrn_q    <= '0;
    end else if (stall_int) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= '0;
      mb_q     <= '0;
      mrn_q    <= '0;
    end else begin
      mwreg_q  <= bus.ewreg;
      mm2reg_q <= bus.em2reg;
      mwmem_q  <= bus.ewmem;
      malu_q   <= em_alu;
      mb_q     <= bus.eb;
      mrn_q    <= ern_int;
    end
  end

  assign bus.ern    = ern_int;
  assign bus.mwreg  = mwreg_q;
  assign bus.mm2reg = mm2reg_q;
  assign bus.mwmem  = mwmem_q;
  assign bus.malu   = malu_q;
  assign bus.mb     = mb_q;
  assign bus.mrn    = mrn_q;

endmodule

// File: tb/tb_pipeexe_emreg.sv
// tb/tb_pipeexe_emreg.sv - directed bench for pipeexe_emreg (multiplier checks under PIPE_MUL_EN)
module tb_pipeexe_emreg;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;

  pipeexe_emreg_if bus ();

  pipeexe_emreg dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                    input logic [3:0] aluc, input logic aluimm, input logic shift,
                    input logic jal, input logic [31:0] pc4, input logic [4:0] rn,
                    input logic wreg, input logic m2reg, input logic wmem);
    bus.ea      = a;
    bus.eb      = b;
    bus.eimm    = imm;
    bus.ealuc   = aluc;
    bus.ealuimm = aluimm;
    bus.eshift  = shift;
    bus.ejal    = jal;
    bus.epc4    = pc4;
    bus.ern0    = rn;
    bus.ewreg   = wreg;
    bus.em2reg  = m2reg;
    bus.ewmem   = wmem;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mwreg"},  32'(bus.mwreg),  32'd0);
    chk({tag, "_mm2reg"}, 32'(bus.mm2reg), 32'd0);
    chk({tag, "_mwmem"},  32'(bus.mwmem),  32'd0);
    chk({tag, "_malu"},   bus.malu,        32'd0);
    chk({tag, "_mb"},     bus.mb,          32'd0);
    chk({tag, "_mrn"},    32'(bus.mrn),    32'd0);
    chk({tag, "_estall"}, 32'(bus.estall), 32'd0);
  endtask

`ifdef PIPE_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [4:0] rd);
    int high;
    high = 0;
    op(a, b, 32'd0, 4'b1011, 1'b0, 1'b0, 1'b0, 32'd0, rd, 1'b1, 1'b0, 1'b0);
    #1;
    if (bus.estall) high++;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk({tag, "_bubble_mwreg"}, 32'(bus.mwreg), 32'd0);
      if (bus.estall) high++;
    end
    step();
    chk({tag, "_done_estall"}, 32'(bus.estall), 32'd0);
    chk({tag, "_done_mwreg"},  32'(bus.mwreg),  32'd0);
    chk({tag, "_stall_cycles"}, 32'(high), 32'd33);
    step();
    chk({tag, "_malu"},  bus.malu,        exp);
    chk({tag, "_mwreg"}, 32'(bus.mwreg),  32'd1);
    chk({tag, "_mrn"},   32'(bus.mrn),    32'(rd));
    chk({tag, "_mb"},    bus.mb,          b);
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    resetn = 1'b0;
    op(32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_zero("reset");
    resetn = 1'b1;

    // add
    op(32'd5, 32'd7, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("add_estall_pre", 32'(bus.estall), 32'd0);
    chk("add_ern",        32'(bus.ern),    32'd3);
    step();
    chk("add_malu",  bus.malu,        32'd12);
    chk("add_mrn",   32'(bus.mrn),    32'd3);
    chk("add_mwreg", 32'(bus.mwreg),  32'd1);
    chk("add_mb",    bus.mb,          32'd7);
    chk("add_estall",32'(bus.estall), 32'd0);

    // sub with load/store controls passing through
    op(32'd5, 32'd7, 32'd0, 4'b0100, 1'b0, 1'b0, 1'b0, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1);
    step();
    chk("sub_malu",   bus.malu,        32'hFFFF_FFFE);
    chk("sub_mm2reg", 32'(bus.mm2reg), 32'd1);
    chk("sub_mwmem",  32'(bus.mwmem),  32'd1);
    chk("sub_mwreg",  32'(bus.mwreg),  32'd0);

    // logic ops
    op(32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk("and_malu", bus.malu, 32'h0000_F000);
    op(32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'b1101, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk("or_malu", bus.malu, 32'h0000_FFF0);
    op(32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk("xor_malu", bus.malu, 32'h0000_0FF0);

    // lui with immediate operand
    op(32'd0, 32'hDEAD_BEEF, 32'h0000_1234, 4'b0110, 1'b1, 1'b0, 1'b0, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk("lui_malu", bus.malu, 32'h1234_0000);
    chk("lui_mb",   bus.mb,   32'hDEAD_BEEF);

    // shifts by eimm[10:6] = 4
    op(32'd0, 32'd1, 32'h0000_0100, 4'b0011, 1'b0, 1'b1, 1'b0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    chk("sll_malu", bus.malu, 32'd16);
    op(32'd0, 32'h8000_0000, 32'h0000_0100, 4'b0111, 1'b0, 1'b1, 1'b0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    chk("srl_malu", bus.malu, 32'h0800_0000);
    op(32'd0, 32'h8000_0000, 32'h0000_0100, 4'b1111, 1'b0, 1'b1, 1'b0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    chk("sra_malu", bus.malu, 32'hF800_0000);

    // jal
    op(32'd9, 32'd9, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    chk("jal_ern", 32'(bus.ern), 32'd31);
    step();
    chk("jal_malu", bus.malu,     32'h0000_0104);
    chk("jal_mrn",  32'(bus.mrn), 32'd31);

    // jal combined with the multiply code: jal wins, no stall
    op(32'd6, 32'd7, 32'd0, 4'b1011, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    chk("jalmul_estall_pre", 32'(bus.estall), 32'd0);
    step();
    chk("jalmul_malu",   bus.malu,        32'h0000_0204);
    chk("jalmul_estall", 32'(bus.estall), 32'd0);

    // asynchronous reset with non-zero E/M contents
    op(32'd1, 32'd2, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1);
    step();
    chk("pre_async_malu", bus.malu, 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("async_reset");
    step();
    resetn = 1'b1;

`ifdef PIPE_MUL_EN
    run_mul("mul_6x7", 32'd6, 32'd7, 32'd42, 5'd9);
    run_mul("mul_ffx2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 5'd10);

    // reset during the 10th BUSY cycle
    op(32'd6, 32'd7, 32'd0, 4'b1011, 1'b0, 1'b0, 1'b0, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    chk("mid_busy_estall", 32'(bus.estall), 32'd1);
    resetn = 1'b0;
    #1;
    chk_zero("mid_mul_reset");
    step();
    resetn = 1'b1;
    run_mul("mul_after_reset", 32'd6, 32'd7, 32'd42, 5'd9);
`else
    op(32'd6, 32'd7, 32'd0, 4'b1011, 1'b0, 1'b0, 1'b0, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mul_off_estall_pre", 32'(bus.estall), 32'd0);
    step();
    chk("mul_off_malu",   bus.malu,        32'd0);
    chk("mul_off_mwreg",  32'(bus.mwreg),  32'd1);
    chk("mul_off_mrn",    32'(bus.mrn),    32'd9);
    chk("mul_off_estall", 32'(bus.estall), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
